// File: rtl/cacheline_adapter.sv
// Converts 256-bit cacheline read/write requests into four 64-bit memory beats.
// Read beats are tagged by address; only beats for the pending line are kept.
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        READ_WAIT,
        WRITE,
        RESP
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   line_q, line_d;
    logic [255:0]   wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            line_q  <= 256'd0;
            wdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        line_d     = line_q;
        wdata_d    = wdata_q;
        dfp_resp   = 1'b0;
        bmem_addr  = 32'd0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = 64'd0;

        case (state_q)
            IDLE: begin
                // Write wins when both requests are raised together.
                if (dfp_write) begin
                    addr_d  = {dfp_addr[31:5], 5'b0};
                    wdata_d = dfp_wdata;
                    cnt_d   = 2'd0;
                    state_d = WRITE;
                end else if (dfp_read) begin
                    addr_d  = {dfp_addr[31:5], 5'b0};
                    cnt_d   = 2'd0;
                    state_d = READ_REQ;
                end
            end
            READ_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) state_d = READ_WAIT;
            end
            READ_WAIT: begin
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    line_d[{cnt_q, 6'd0} +: 64] = bmem_rdata;
                    if (cnt_q == 2'd3) state_d = RESP;
                    else               cnt_d   = cnt_q + 2'd1;
                end
            end
            WRITE: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wdata_q[{cnt_q, 6'd0} +: 64];
                if (bmem_ready) begin
                    if (cnt_q == 2'd3) state_d = RESP;
                    else               cnt_d   = cnt_q + 2'd1;
                end
            end
            RESP: begin
                dfp_resp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dfp_rdata = line_q;

endmodule
